// File: rtl/seq_rshifter.sv
// Sequential right shifter: one bit per cycle, logical or arithmetic fill,
// with a valid/ready handshake on both operand and result sides.
module seq_rshifter #(
   parameter  int DATA_W = 8,
   localparam int CNT_W  = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] ina,
   input  logic [CNT_W-1:0]  shift,
   input  logic              arith,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] data, data_nxt;
   logic [CNT_W-1:0]  count, count_nxt;
   logic              mode, mode_nxt;
   logic              accept;

   // One-bit right step; the vacated MSB takes the sign bit only in arithmetic mode.
   function automatic logic [DATA_W-1:0] shr1(input logic [DATA_W-1:0] d,
                                              input logic              m);
      return {m & d[DATA_W-1], d[DATA_W-1:1]};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         data  <= '0;
         count <= '0;
         mode  <= 1'b0;
      end else begin
         state <= state_nxt;
         data  <= data_nxt;
         count <= count_nxt;
         mode  <= mode_nxt;
      end
   end

   // in_ready is gated by rst_n so it stays low for the whole reset window.
   assign in_ready  = (state == IDLE) && rst_n;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out       = (state == DONE) ? data : '0;

   always_comb begin
      state_nxt = state;
      data_nxt  = data;
      count_nxt = count;
      mode_nxt  = mode;
      unique case (state)
         IDLE: begin
            if (accept) begin
               data_nxt  = ina;
               count_nxt = shift;
               mode_nxt  = arith;
               state_nxt = (shift == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            data_nxt  = shr1(data, mode);
            count_nxt = count - CNT_W'(1);
            if (count == CNT_W'(1)) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
